// File: rtl/bias_load_ctrl_pkg.sv
// bias_load_ctrl_pkg: FSM encoding and package-size derivations for the bias loader
package bias_load_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, REQ, RECV, DONE} state_t;
  function automatic int pkg_len(input int dw, input int fw);
    return dw / fw;
  endfunction
  function automatic int pkg_num(input int rl, input int dw, input int fw);
    return rl / (dw / fw);
  endfunction
  function automatic logic [5:0] calc_npkg(input int num, input int pl, input int pn);
    int p;
    p = (num + pl - 1) / pl;
    return 6'(p > pn ? pn : p);
  endfunction
endpackage

// File: rtl/bias_load_ctrl.sv
// bias_load_ctrl: fetches a layer's bias block in one burst and streams it into the bias array
module bias_load_ctrl
  import bias_load_ctrl_pkg::*;
#(
  parameter int DW = 512,
  parameter int FW = 32,
  parameter int RL = 512,
  parameter int AW = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic [9:0]    bias_num_i,
  input  logic [AW-1:0] base_addr_i,
  output logic          rd_req_o,
  output logic [AW-1:0] rd_addr_o,
  output logic [5:0]    rd_len_o,
  input  logic          rd_ack_i,
  input  logic          rd_valid_i,
  input  logic [DW-1:0] rd_data_i,
  output logic          bias_en_o,
  output logic [4:0]    bias_addr_o,
  output logic [DW-1:0] bias_data_o,
  output logic          busy_o,
  output logic          done_o
);
  localparam int PKG_LEN = pkg_len(DW, FW);
  localparam int PKG_NUM = pkg_num(RL, DW, FW);
  state_t state, state_n;
  logic [5:0] cnt;
  logic beat, last, load;
  // next state and state-decoded outputs
  always_comb begin
    beat = state == RECV && rd_valid_i;
    last = beat && cnt == 6'(rd_len_o - 6'd1);
    load = state == IDLE && start_i && bias_num_i != 10'd0;
    rd_req_o = state == REQ;
    busy_o = state != IDLE;
    done_o = state == DONE;
    state_n = state == IDLE ? (start_i ? (bias_num_i == 10'd0 ? DONE : REQ) : IDLE) :
              state == REQ  ? (rd_ack_i ? RECV : REQ) :
              state == RECV ? (last ? DONE : RECV) : IDLE;
  end
  // state register
  always_ff @(posedge clk_i)
    state <= rst_i ? IDLE : state_n;
  // request latching, beat counting and the one-cycle write pipeline
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_addr_o <= '0;
      rd_len_o <= '0;
      cnt <= '0;
      bias_en_o <= 1'b0;
      bias_addr_o <= '0;
      bias_data_o <= '0;
    end else begin
      bias_en_o <= beat;
      if (beat) begin
        bias_addr_o <= cnt[4:0];
        bias_data_o <= rd_data_i;
        cnt <= cnt + 6'd1;
      end
      if (load) begin
        rd_addr_o <= base_addr_i;
        rd_len_o <= calc_npkg(32'(bias_num_i), PKG_LEN, PKG_NUM);
        cnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_bias_load_ctrl.sv
// tb_bias_load_ctrl: directed self-checking bench for bias_load_ctrl
module tb_bias_load_ctrl;
  logic clk_i = 1'b0, rst_i = 1'b1, start_i = 1'b0, rd_ack_i = 1'b0, rd_valid_i = 1'b0;
  logic [9:0] bias_num_i = '0;
  logic [31:0] base_addr_i = '0, rd_addr_o;
  logic [511:0] rd_data_i = '0, bias_data_o;
  logic rd_req_o, bias_en_o, busy_o, done_o;
  logic [5:0] rd_len_o;
  logic [4:0] bias_addr_o;
  int checks = 0, errors = 0;

  bias_load_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .bias_num_i(bias_num_i),
    .base_addr_i(base_addr_i), .rd_req_o(rd_req_o), .rd_addr_o(rd_addr_o),
    .rd_len_o(rd_len_o), .rd_ack_i(rd_ack_i), .rd_valid_i(rd_valid_i),
    .rd_data_i(rd_data_i), .bias_en_o(bias_en_o), .bias_addr_o(bias_addr_o),
    .bias_data_o(bias_data_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [511:0] pat(input int i);
    return {16{32'(i) * 32'h0101_0101 ^ 32'hDEAD_0000}};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_busy"}, 512'(busy_o), 0);
    chk({tag, "_done"}, 512'(done_o), 0);
    chk({tag, "_en"}, 512'(bias_en_o), 0);
    chk({tag, "_req"}, 512'(rd_req_o), 0);
  endtask

  task automatic start(input int num, input logic [31:0] base);
    start_i = 1'b1;
    bias_num_i = 10'(num);
    base_addr_i = base;
    tick();
    start_i = 1'b0;
  endtask

  task automatic ack();
    rd_ack_i = 1'b1;
    tick();
    rd_ack_i = 1'b0;
    chk("ack_req_drop", 512'(rd_req_o), 0);
    chk("ack_busy", 512'(busy_o), 1);
  endtask

  task automatic beat(input int idx, input logic exp_done);
    rd_valid_i = 1'b1;
    rd_data_i = pat(idx);
    tick();
    rd_valid_i = 1'b0;
    chk("wr_en", 512'(bias_en_o), 1);
    chk("wr_addr", 512'(bias_addr_o), 512'(idx));
    chk("wr_data", bias_data_o, pat(idx));
    chk("wr_done", 512'(done_o), 512'(exp_done));
  endtask

  task automatic gap();
    tick();
    chk("gap_en", 512'(bias_en_o), 0);
    chk("gap_done", 512'(done_o), 0);
  endtask

  initial begin
    tick();
    tick();
    chk("rst_addr", 512'(rd_addr_o), 0);
    chk("rst_len", 512'(rd_len_o), 0);
    chk("rst_baddr", 512'(bias_addr_o), 0);
    chk("rst_bdata", bias_data_o, 0);
    idle_chk("rst");
    rst_i = 1'b0;
    rd_valid_i = 1'b1;
    tick();
    rd_valid_i = 1'b0;
    chk("stray_idle_en", 512'(bias_en_o), 0);

    start(512, 32'h1000);
    for (int i = 0; i < 3; i++) begin
      chk("t1_req", 512'(rd_req_o), 1);
      chk("t1_addr", 512'(rd_addr_o), 32'h1000);
      chk("t1_len", 512'(rd_len_o), 32);
      chk("t1_busy", 512'(busy_o), 1);
      if (i < 2) tick();
    end
    ack();
    for (int i = 0; i < 32; i++) beat(i, i == 31);
    tick();
    idle_chk("t1_end");

    start(20, 32'h40);
    chk("t2_len", 512'(rd_len_o), 2);
    chk("t2_addr", 512'(rd_addr_o), 32'h40);
    ack();
    beat(0, 1'b0);
    beat(1, 1'b1);
    rd_valid_i = 1'b1;
    tick();
    rd_valid_i = 1'b0;
    idle_chk("t2_extra");

    start(0, 32'h77);
    chk("t3_done", 512'(done_o), 1);
    chk("t3_busy", 512'(busy_o), 1);
    chk("t3_req", 512'(rd_req_o), 0);
    tick();
    idle_chk("t3_end");

    start(600, 32'h2000);
    chk("t4_len", 512'(rd_len_o), 32);
    ack();
    for (int i = 0; i < 32; i++) begin
      if (i == 5) begin
        start_i = 1'b1;
        bias_num_i = 10'd1;
        base_addr_i = 32'h0;
      end
      if (i % 3 == 2) gap();
      start_i = 1'b0;
      beat(i, i == 31);
    end
    chk("t4_addr_hold", 512'(rd_addr_o), 32'h2000);
    chk("t4_len_hold", 512'(rd_len_o), 32);
    tick();
    idle_chk("t4_end");

    start(512, 32'h5000);
    ack();
    for (int i = 0; i < 10; i++) beat(i, 1'b0);
    rst_i = 1'b1;
    rd_valid_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("t5_addr", 512'(rd_addr_o), 0);
    chk("t5_len", 512'(rd_len_o), 0);
    chk("t5_baddr", 512'(bias_addr_o), 0);
    chk("t5_bdata", bias_data_o, 0);
    idle_chk("t5_rst");
    tick();
    rd_valid_i = 1'b0;
    idle_chk("t5_post");
    start(64, 32'h3000);
    chk("t5_len2", 512'(rd_len_o), 4);
    chk("t5_addr2", 512'(rd_addr_o), 32'h3000);
    ack();
    for (int i = 0; i < 4; i++) beat(i + 0, i == 3);
    tick();
    idle_chk("t5_end");

    start(16, 32'h9000);
    rd_valid_i = 1'b1;
    tick();
    rd_valid_i = 1'b0;
    chk("t6_req_en", 512'(bias_en_o), 0);
    chk("t6_req_hold", 512'(rd_req_o), 1);
    chk("t6_len", 512'(rd_len_o), 1);
    ack();
    beat(0, 1'b1);
    tick();
    idle_chk("t6_end");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
